// File: rtl/simple_processor_pkg.sv
// Shared types and widths for the instruction fetch front end.
//   DATA_WIDTH  : IMEM word width (two halfword instructions per word)
//   ADDR_WIDTH  : byte address width of the PC and IMEM
//   INSTR_WIDTH : width of one compressed instruction
//   TAG_WIDTH   : word-address part of the PC kept as the buffer tag
package simple_processor_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 32;
  localparam int INSTR_WIDTH = 16;
  localparam int TAG_WIDTH   = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// One-word instruction buffer with word tag and valid bit.
//   clk_i, arst_ni : clock, async active-low reset
//   load_i         : capture data_i/tag_i and mark valid
//   inv_i          : drop valid (data and tag are kept; load wins over inv)
//   data_o/tag_o/valid_o : buffered word, its word address, valid flag
module fetch_buf
  import simple_processor_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  load_i,
  input  logic                  inv_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [TAG_WIDTH-1:0]  tag_o,
  output logic                  valid_o
);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      data_o  <= '0;
      tag_o   <= '0;
      valid_o <= 1'b0;
    end else if (load_i) begin
      data_o  <= data_i;
      tag_o   <= tag_i;
      valid_o <= 1'b1;
    end else if (inv_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch unit: halfword PC, single outstanding IMEM read, and a
// one-word buffer so the second halfword of a word needs no IMEM access.
//   clk_i, arst_ni          : clock, async active-low reset
//   imem_req_o/imem_addr_o  : IMEM read request and word-aligned address
//   imem_ack_i/imem_rdata_i : IMEM read data valid and data
//   stall_i                 : downstream hold of PC and presented word
//   valid_pc_i              : decoder verdict, 0 = illegal -> restart at boot
//   if_valid_o/if_rdata_o/if_addr_o : presented word and PC
module ins_fetch
  import simple_processor_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ack_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  stall_i,
  input  logic                  valid_pc_i,
  output logic                  if_valid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic [ADDR_WIDTH-1:0] if_addr_o
);

  // Boot PC with bit 0 cleared so the PC stays halfword aligned.
  localparam logic [ADDR_WIDTH-1:0] PC_RST = {BOOT_ADDR[ADDR_WIDTH-1:1], 1'b0};

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic                  buf_load, buf_inv, buf_valid;
  logic [TAG_WIDTH-1:0]  buf_tag;

  // Wraps modulo 2^ADDR_WIDTH.
  assign pc_inc = pc_q + ADDR_WIDTH'(2);

  fetch_buf u_buf (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .load_i  (buf_load),
    .inv_i   (buf_inv),
    .data_i  (imem_rdata_i),
    .tag_i   (pc_q[ADDR_WIDTH-1:2]),
    .data_o  (if_rdata_o),
    .tag_o   (buf_tag),
    .valid_o (buf_valid)
  );

  // State and PC registers
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state, next PC and buffer control. Acks are only honoured in
  // S_REQ, so a late ack from an abandoned request falls on the floor.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    buf_load = 1'b0;
    buf_inv  = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ack_i) begin
          buf_load = 1'b1;
          state_d  = S_VALID;
        end
      end
      S_VALID: begin
        if (!stall_i) begin
          if (valid_pc_i) begin
            pc_d = pc_inc;
            // Stepping into the upper halfword of the buffered word is free.
            if (pc_inc[ADDR_WIDTH-1:2] != buf_tag) begin
              buf_inv = 1'b1;
              state_d = S_REQ;
            end
          end else begin
            // Illegal instruction: always refetch from boot, even on a tag hit.
            pc_d    = PC_RST;
            buf_inv = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    imem_req_o  = (state_q == S_REQ);
    imem_addr_o = {pc_q[ADDR_WIDTH-1:2], 2'b00};
    if_valid_o  = (state_q == S_VALID) && buf_valid;
    if_addr_o   = pc_q;
  end

endmodule
